// File: rtl/time_display_pkg.sv
// rtl/time_display_pkg.sv - shared types, constants and segment decoder for time_display
package time_display_pkg;

    typedef enum logic [1:0] {
        CAPTURE,
        SHIFT,
        IDLE,
        COMMIT
    } conv_state_t;

    localparam int NUM_DIGITS = 6;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // dp is active-low; zeros mark the HH.MM.SS separators at idx2 and idx4
    localparam logic [5:0] DP_MASK = 6'b101011;

    // Digit-register code used for an out-of-range field
    localparam logic [3:0] DIGIT_DASH = 4'hA;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/time_display_bin2bcd_seq.sv
// rtl/time_display_bin2bcd_seq.sv - 7-bit sequential double-dabble binary to BCD converter
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] bin,
    output logic [7:0] bcd,
    output logic       done
);

    logic [6:0] bin_q;
    logic [2:0] steps;
    logic [7:0] adj;

    // Add 3 to any BCD nibble >= 5 ahead of the next shift
    always_comb begin
        adj = bcd;
        if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
    end

    // High during the final shift cycle so the sequencer can commit on the next edge
    assign done = (steps == 3'd1);

    // Load on start, then run seven adjust-and-shift steps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q <= '0;
            bcd   <= '0;
            steps <= '0;
        end else if (start) begin
            bin_q <= bin;
            bcd   <= '0;
            steps <= 3'd7;
        end else if (steps != 3'd0) begin
            {bcd, bin_q} <= {adj, bin_q} << 1;
            steps        <= steps - 3'd1;
        end
    end

endmodule

// File: rtl/time_display.sv
// rtl/time_display.sv - multiplexed HH.MM.SS six-digit seven-segment driver
module time_display
    import time_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] second,
    input  logic [6:0] minute,
    input  logic [6:0] hour,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          tick;
    logic          wrap;

    conv_state_t   state;
    logic [6:0]    sh_sec, sh_min, sh_hr;
    logic [NUM_DIGITS-1:0][3:0] digit;

    logic [7:0]    bcd_sec, bcd_min, bcd_hr;
    logic          done_sec, done_min, done_hr;
    logic          start;
    logic          sec_ok, min_ok, hr_ok;

    assign tick   = (cnt == CW'(SCAN_DIV - 1));
    assign wrap   = tick && (idx == 3'd5);
    assign start  = (state == CAPTURE);
    assign sec_ok = (sh_sec <= 7'd59);
    assign min_ok = (sh_min <= 7'd59);
    assign hr_ok  = (sh_hr  <= 7'd23);

    bin2bcd_seq u_sec (.clk(clk), .rst(rst), .start(start), .bin(second), .bcd(bcd_sec), .done(done_sec));
    bin2bcd_seq u_min (.clk(clk), .rst(rst), .start(start), .bin(minute), .bcd(bcd_min), .done(done_min));
    bin2bcd_seq u_hr  (.clk(clk), .rst(rst), .start(start), .bin(hour),   .bcd(bcd_hr),  .done(done_hr));

    // Prescaler and digit scan counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    // Conversion sequencer: snapshot once per frame, convert, then commit digits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= CAPTURE;
            sh_sec <= '0;
            sh_min <= '0;
            sh_hr  <= '0;
            digit  <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    sh_sec <= second;
                    sh_min <= minute;
                    sh_hr  <= hour;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (done_sec && done_min && done_hr) state <= COMMIT;
                end
                COMMIT: begin
                    digit[0] <= sec_ok ? bcd_sec[3:0] : DIGIT_DASH;
                    digit[1] <= sec_ok ? bcd_sec[7:4] : DIGIT_DASH;
                    digit[2] <= min_ok ? bcd_min[3:0] : DIGIT_DASH;
                    digit[3] <= min_ok ? bcd_min[7:4] : DIGIT_DASH;
                    digit[4] <= hr_ok  ? bcd_hr[3:0]  : DIGIT_DASH;
                    digit[5] <= hr_ok  ? bcd_hr[7:4]  : DIGIT_DASH;
                    state    <= IDLE;
                end
                IDLE: begin
                    if (wrap) state <= CAPTURE;
                end
                default: state <= CAPTURE;
            endcase
        end
    end

    // Registered display outputs follow the scan index one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 6'b111110;
            seg <= SEG_0;
            dp  <= 1'b1;
        end else begin
            an  <= ~(6'b000001 << idx);
            seg <= seg_decode(digit[idx]);
            dp  <= DP_MASK[idx];
        end
    end

endmodule

// File: tb/tb_time_display.sv
// tb/tb_time_display.sv - directed self-checking bench for time_display
module tb_time_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] second, minute, hour;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    int checks = 0;
    int errors = 0;

    time_display #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .second(second), .minute(minute), .hour(hour),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic wait_entry(input logic [5:0] pat, output bit ok);
        bit seen_other = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (an !== pat) seen_other = 1'b1;
            else if (seen_other) ok = 1'b1;
            if (!ok) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        second = 7'd45; minute = 7'd34; hour = 7'd12;
        repeat (3) @(negedge clk);
        checks++; if (an !== 6'b111110) begin errors++; $display("FAIL reset_an got %b want 111110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
    endtask

    task automatic test_latency();
        rst = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++; if (dut.digit[0] !== 4'd0 || dut.digit[1] !== 4'd0) begin
            errors++; $display("FAIL latency_early got %0d/%0d want 0/0", dut.digit[1], dut.digit[0]);
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (dut.digit[0] !== 4'd5 || dut.digit[1] !== 4'd4) begin
            errors++; $display("FAIL latency_commit got %0d/%0d want 4/5", dut.digit[1], dut.digit[0]);
        end
    endtask

    task automatic test_scan();
        int exp_d [6] = '{6, 5, 4, 3, 2, 1};
        logic [5:0] exp_an;
        bit ok;
        int len;
        second = 7'd56;
        repeat (60) @(negedge clk);
        wait_entry(6'b111110, ok);
        checks++; if (!ok) begin errors++; $display("FAIL scan_entry timeout got 0 want 1"); end
        for (int i = 0; i < 6; i++) begin
            exp_an = ~(6'b000001 << i);
            checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an%0d got %b want %b", i, an, exp_an); end
            checks++; if (seg !== exp_seg(exp_d[i])) begin errors++; $display("FAIL scan_seg%0d got %b want %b", i, seg, exp_seg(exp_d[i])); end
            checks++; if (dp !== ((i == 2 || i == 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL scan_dp%0d got %b", i, dp); end
            len = 0;
            while (an === exp_an && len < 50) begin len++; @(negedge clk); end
            checks++; if (len != 4) begin errors++; $display("FAIL scan_len%0d got %0d want 4", i, len); end
        end
    endtask

    task automatic test_midframe_change();
        int exp_d [6] = '{9, 5, 9, 5, 3, 2};
        logic [5:0] exp_an;
        bit ok;
        int len;
        second = 7'd59; minute = 7'd59; hour = 7'd23;
        repeat (60) @(negedge clk);
        wait_entry(6'b111110, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_entry timeout got 0 want 1"); end
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin second = 7'd0; minute = 7'd0; hour = 7'd0; end
            exp_an = ~(6'b000001 << i);
            checks++; if (seg !== exp_seg(exp_d[i]) || an !== exp_an) begin
                errors++; $display("FAIL mid_slot%0d got seg %b an %b want seg %b an %b", i, seg, an, exp_seg(exp_d[i]), exp_an);
            end
            len = 0;
            while (an === exp_an && len < 50) begin len++; @(negedge clk); end
        end
        repeat (7) @(posedge clk);
        @(negedge clk);
        checks++; if (dut.digit[0] !== 4'd9) begin errors++; $display("FAIL mid_before_commit got %0d want 9", dut.digit[0]); end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++; if (dut.digit[k] !== 4'd0) begin errors++; $display("FAIL mid_zero%0d got %0d want 0", k, dut.digit[k]); end
        end
    endtask

    task automatic test_validity();
        int exp_d [6] = '{7, 0, 10, 10, 10, 10};
        logic [5:0] exp_an;
        bit ok;
        int len;
        second = 7'd7; minute = 7'd60; hour = 7'd24;
        repeat (60) @(negedge clk);
        wait_entry(6'b111110, ok);
        checks++; if (!ok) begin errors++; $display("FAIL valid_entry timeout got 0 want 1"); end
        for (int i = 0; i < 6; i++) begin
            exp_an = ~(6'b000001 << i);
            checks++; if (seg !== exp_seg(exp_d[i]) || an !== exp_an) begin
                errors++; $display("FAIL valid_slot%0d got seg %b an %b want seg %b an %b", i, seg, an, exp_seg(exp_d[i]), exp_an);
            end
            len = 0;
            while (an === exp_an && len < 50) begin len++; @(negedge clk); end
        end
    endtask

    task automatic test_reset_during_shift();
        int exp_d [6] = '{0, 3, 0, 2, 0, 1};
        bit ok;
        second = 7'd56; minute = 7'd34; hour = 7'd12;
        repeat (60) @(negedge clk);
        wait_entry(6'b111110, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rshift_entry timeout got 0 want 1"); end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (an !== 6'b111110) begin errors++; $display("FAIL rshift_an got %b want 111110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL rshift_seg got %b want 1000000", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rshift_dp got %b want 1", dp); end
        checks++; if (dut.digit !== '0) begin errors++; $display("FAIL rshift_digits got %h want 0", dut.digit); end
        second = 7'd30; minute = 7'd20; hour = 7'd10;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++; if (dut.digit !== '0) begin errors++; $display("FAIL rshift_stale got %h want 0", dut.digit); end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++; if (dut.digit[k] !== 4'(exp_d[k])) begin errors++; $display("FAIL rshift_fresh%0d got %0d want %0d", k, dut.digit[k], exp_d[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scan();
        test_midframe_change();
        test_validity();
        test_reset_during_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_display.md
# time_display

Multiplexed six-digit seven-segment driver for the wall-clock time counter. It consumes the binary `second`/`minute`/`hour` values the counter produces and converts each to BCD with a sequential converter. It scans the digits as HH.MM.SS onto a common-anode display. Inputs are snapshotted once per scan frame, so digits never tear mid-frame.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); must be ≥ 16.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `second`  in  7: binary seconds, valid 0–59.
- `minute`  in  7: binary minutes, valid 0–59.
- `hour`  in  7: binary hours, valid 0–23.
- `seg`  out  7: segment cathodes, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1: decimal point, active-low.
- `an`  out  6: digit anodes, active-low, exactly one low at all times.

## Operation
- Prescaler `cnt` runs 0..SCAN_DIV-1 and wraps. `tick` = (`cnt` == SCAN_DIV-1).
- Digit index `idx` runs 0..5. It advances on `tick` and wraps 5→0.
- Digit map:
  - idx0 = sec ones, idx1 = sec tens
  - idx2 = min ones, idx3 = min tens
  - idx4 = hour ones, idx5 = hour tens
  - `dp` is low on idx2 and idx4 (separators) and high elsewhere.
- Converter FSM:
  - CAPTURE: latch `second`/`minute`/`hour` into shadow registers, clear BCD scratch, go to SHIFT.
  - SHIFT: 7 cycles of double-dabble on all three fields in parallel (add 3 to any nibble ≥5, then shift left). Go to COMMIT.
  - COMMIT: write the six digit registers, go to IDLE.
  - IDLE: on the `tick` that wraps `idx` 5→0, go to CAPTURE.
- Validity is checked on the shadow values in COMMIT. Second or minute > 59, or hour > 23, makes both digits of that field show a dash (`seg`=0111111). Other fields are unaffected.
- Segment patterns, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111
- Leading zeros are displayed; there is no blanking.

## Timing
- Reset values (asynchronous):
  - `cnt`=0, `idx`=0, FSM=CAPTURE, all digit registers=0.
  - `an`=111110, `seg`=1000000, `dp`=1.
- First capture is at the first rising edge after `rst` deasserts.
- `an`/`seg`/`dp` are registered and reflect the new `idx` one cycle after `tick`.
- Conversion latency: capture edge + 8 cycles (1 CAPTURE + 7 SHIFT) → digit registers valid at the COMMIT edge.
  - idx0 of a new frame shows the previous frame's value for those ≤9 cycles. This is accepted.
- Input changes between captures have no visible effect until the next frame boundary.
- Reset mid-frame or mid-conversion: all state returns to reset values immediately; any partial conversion is discarded.
- Capture and `tick` can coincide: capture uses the input values present that cycle.

## Structure
- Package `time_display_pkg` holds:
  - the FSM state enum (CAPTURE, SHIFT, IDLE, COMMIT)
  - `NUM_DIGITS`=6
  - the ten digit segment constants, `SEG_DASH`
  - the dp mask 6'b101011
- One sub-module, `bin2bcd_seq`: 7-bit sequential double-dabble with `start`/`done` and 8-bit BCD out. It is instantiated three times.
- Top level holds the prescaler, scan counter, FSM sequencing, validity check and output registers.

## Test plan
- Reset: hold `rst`=0 → `an`=111110, `seg`=1000000, `dp`=1. Release → capture occurs on the next edge.
- SCAN_DIV=4, inputs 12:34:56 → digits idx0..5 show 6,5,4,3,2,1. `dp` is low only at idx2/idx4. Each `an` slot lasts 4 cycles.
- Change 23:59:59 → 00:00:00 mid-frame → remaining slots still show 23:59:59. After the 5→0 wrap plus 8 cycles, all digits show 0.
- Field validity: minute=60, hour=24, second=7 → idx2/3 and idx4/5 show 0111111. idx0 shows 7 (1111000), idx1 shows 0.
- Conversion latency: at capture with second=45 → sec digit registers update exactly 8 cycles later to 5/4.
- Reset pulse during SHIFT → outputs go to reset values asynchronously. A fresh capture occurs after release, with no stale digits.
